// File: rtl/mp8_seq_ctrl.sv
// mp8_seq_ctrl: fetch/decode/execute sequencer for the MP-8 core.
// Holds PC and IR, drives the shared instruction/data memory and issues
// accumulator-load / ALU-select strobes to the datapath.
// Optional build macro: MP8_SINGLE_STEP_EN adds a 'step' input that makes
// FETCH wait until step is sampled high.
module mp8_seq_ctrl #(
  parameter int            AW       = 5,
  parameter int            DW       = 8,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] RD,
  input  logic [DW-1:0] acc,
  input  logic          zero,
`ifdef MP8_SINGLE_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] addr,
  output logic [DW-1:0] WD,
  output logic          WE,
  output logic          acc_we,
  output logic [1:0]    alu_op,
  output logic [AW-1:0] pc,
  output logic [DW-1:0] ir,
  output logic          halted
);

  localparam int OW = DW - AW;

  localparam logic [OW-1:0] OP_LDA = OW'(0);
  localparam logic [OW-1:0] OP_STA = OW'(1);
  localparam logic [OW-1:0] OP_ADD = OW'(2);
  localparam logic [OW-1:0] OP_SUB = OW'(3);
  localparam logic [OW-1:0] OP_JMP = OW'(4);
  localparam logic [OW-1:0] OP_JZ  = OW'(5);
  localparam logic [OW-1:0] OP_NOP = OW'(6);
  localparam logic [OW-1:0] OP_HLT = OW'(7);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_STORE,
    S_HALT
  } state_t;

  state_t        state;
  logic [OW-1:0] opcode;
  logic [AW-1:0] operand;
  logic          fetchGo;

  assign opcode  = ir[DW-1:AW];
  assign operand = ir[AW-1:0];
  assign WD      = acc;

`ifdef MP8_SINGLE_STEP_EN
  assign fetchGo = step;
`else
  assign fetchGo = 1'b1;
`endif

  // Sequencer: advances FETCH -> DECODE -> EXEC/STORE/FETCH/HALT and owns PC and IR.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (fetchGo) begin
            ir    <= RD;
            pc    <= pc + AW'(1);
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: state <= S_EXEC;
            OP_STA: state <= S_STORE;
            OP_JMP: begin
              pc    <= operand;
              state <= S_FETCH;
            end
            OP_JZ: begin
              if (zero) pc <= operand;
              state <= S_FETCH;
            end
            OP_NOP: state <= S_FETCH;
            OP_HLT: state <= S_HALT;
            default: state <= S_FETCH;
          endcase
        end
        S_EXEC, S_STORE: state <= S_FETCH;
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  // Memory and datapath strobes are a pure decode of the current state and IR.
  always_comb begin
    addr   = pc;
    WE     = 1'b0;
    acc_we = 1'b0;
    alu_op = 2'b00;
    halted = 1'b0;
    case (state)
      S_EXEC: begin
        addr   = operand;
        acc_we = 1'b1;
        case (opcode)
          OP_ADD:  alu_op = 2'b01;
          OP_SUB:  alu_op = 2'b10;
          default: alu_op = 2'b00;
        endcase
      end
      S_STORE: begin
        addr = operand;
        WE   = 1'b1;
      end
      S_HALT: halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mp8_seq_ctrl.sv
// tb_mp8_seq_ctrl: bench for mp8_seq_ctrl with a behavioural memory/accumulator
// environment and an instruction-level reference model of the MP-8 ISA.
// Build with MP8_SINGLE_STEP_EN defined to exercise the step input as well.
module tb_mp8_seq_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RD;
  logic [7:0] accEnv;
  logic       zero;
  logic [4:0] addr;
  logic [7:0] WD;
  logic       WE;
  logic       acc_we;
  logic [1:0] alu_op;
  logic [4:0] pc;
  logic [7:0] ir;
  logic       halted;
`ifdef MP8_SINGLE_STEP_EN
  logic       step;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] envMem[32];
  bit   [7:0] imgMem[32];
  logic       loadAll;
  int         haltCount = 0;

  typedef struct {
    bit [4:0] addr;
    bit       we;
    bit       accWe;
    bit [1:0] aluOp;
    bit       halted;
    bit [4:0] pc;
    bit [7:0] ir;
    bit       isFetch;
    bit       setAcc;
    bit [7:0] newAcc;
    bit       setMem;
    bit [4:0] memAddr;
    bit [7:0] memVal;
  } cyc_t;

  cyc_t     expQ[$];
  bit [4:0] mPc;
  bit [7:0] mIr;
  bit [7:0] mAcc;
  bit [7:0] mMem[32];
  bit       mHalted;
  bit       modelValid = 1'b0;

  mp8_seq_ctrl dut (
    .CLK    (CLK),
    .RST    (RST),
    .RD     (RD),
    .acc    (accEnv),
    .zero   (zero),
`ifdef MP8_SINGLE_STEP_EN
    .step   (step),
`endif
    .addr   (addr),
    .WD     (WD),
    .WE     (WE),
    .acc_we (acc_we),
    .alu_op (alu_op),
    .pc     (pc),
    .ir     (ir),
    .halted (halted)
  );

  always #5 CLK = ~CLK;

  assign RD   = envMem[addr];
  assign zero = (accEnv == 8'd0);

  // Environment: asynchronous-read memory plus the datapath accumulator fed by the DUT strobes.
  always @(posedge CLK) begin
    if (loadAll) begin
      for (int a = 0; a < 32; a++) envMem[a] <= imgMem[a];
      accEnv <= 8'd0;
    end else begin
      if (WE === 1'b1) envMem[addr] <= WD;
      if (acc_we === 1'b1) begin
        case (alu_op)
          2'b00:   accEnv <= RD;
          2'b01:   accEnv <= accEnv + RD;
          2'b10:   accEnv <= accEnv - RD;
          default: ;
        endcase
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Interprets one instruction and queues the cycle-by-cycle outputs it must produce.
  task automatic genInstr();
    cyc_t     c;
    bit [7:0] instr;
    bit [2:0] opc;
    bit [4:0] opnd;
    bit [4:0] nextPc;
    c = '{default: 0};
    if (mHalted) begin
      c.addr = mPc; c.pc = mPc; c.ir = mIr; c.halted = 1'b1;
      expQ.push_back(c);
      return;
    end
    c.addr = mPc; c.pc = mPc; c.ir = mIr; c.isFetch = 1'b1;
    expQ.push_back(c);
    instr  = mMem[mPc];
    opc    = instr[7:5];
    opnd   = instr[4:0];
    nextPc = mPc + 5'd1;
    c = '{default: 0};
    c.addr = nextPc; c.pc = nextPc; c.ir = instr;
    expQ.push_back(c);
    c = '{default: 0};
    c.pc = nextPc; c.ir = instr; c.addr = opnd;
    case (opc)
      3'd0, 3'd2, 3'd3: begin
        c.accWe  = 1'b1;
        c.setAcc = 1'b1;
        if (opc == 3'd0) begin c.aluOp = 2'b00; c.newAcc = mMem[opnd]; end
        else if (opc == 3'd2) begin c.aluOp = 2'b01; c.newAcc = mAcc + mMem[opnd]; end
        else begin c.aluOp = 2'b10; c.newAcc = mAcc - mMem[opnd]; end
        expQ.push_back(c);
      end
      3'd1: begin
        c.we = 1'b1; c.setMem = 1'b1; c.memAddr = opnd; c.memVal = mAcc;
        expQ.push_back(c);
      end
      3'd4: nextPc = opnd;
      3'd5: if (mAcc == 8'd0) nextPc = opnd;
      3'd7: mHalted = 1'b1;
      default: ;
    endcase
    mPc = nextPc;
    mIr = instr;
  endtask

  // Compare process: every cycle after the first reset, DUT outputs must match the model.
  initial begin : compareProc
    cyc_t e;
    cyc_t lastRec;
    bit   lastFetch;
    lastFetch = 1'b0;
    lastRec   = '{default: 0};
    forever begin
      @(negedge CLK);
      if (modelValid) begin
        if (expQ.size() == 0) genInstr();
        e = expQ.pop_front();
        checkOutput("addr", addr, e.addr);
        checkOutput("WE", WE, e.we);
        checkOutput("acc_we", acc_we, e.accWe);
        checkOutput("alu_op", alu_op, e.aluOp);
        checkOutput("halted", halted, e.halted);
        checkOutput("pc", pc, e.pc);
        checkOutput("ir", ir, e.ir);
        checkOutput("WD_eq_acc", WD, accEnv);
        checkOutput("acc_model", accEnv, mAcc);
        if (e.we) checkOutput("store_data", WD, e.memVal);
        if (e.setAcc) mAcc = e.newAcc;
        if (e.setMem) mMem[e.memAddr] = e.memVal;
        lastRec   = e;
        lastFetch = e.isFetch;
      end
      @(posedge CLK);
      if (RST === 1'b1) begin
        expQ.delete();
        mPc = 5'd0; mIr = 8'd0; mHalted = 1'b0;
        modelValid = 1'b1;
        lastFetch  = 1'b0;
      end
`ifdef MP8_SINGLE_STEP_EN
      else if (modelValid && lastFetch && step !== 1'b1) expQ.push_front(lastRec);
`endif
      if (loadAll === 1'b1) begin
        mMem = imgMem;
        mAcc = 8'd0;
      end
    end
  end

  task automatic waitCycle();
    @(negedge CLK);
    #1;
  endtask

  // Holds reset two cycles, optionally loading imgMem into memory during the second.
  task automatic doReset(input bit load);
    @(posedge CLK); #1;
    RST = 1'b1; loadAll = 1'b0;
    @(posedge CLK); #1;
    loadAll = load;
    @(posedge CLK); #1;
    RST = 1'b0; loadAll = 1'b0;
  endtask

  task automatic clearImage();
    for (int a = 0; a < 32; a++) imgMem[a] = 8'd0;
  endtask

  task automatic loadProgB();
    clearImage();
    imgMem[0]  = 8'b000_10000;
    imgMem[1]  = 8'b010_10001;
    imgMem[2]  = 8'b001_10010;
    imgMem[3]  = 8'hFF;
    imgMem[16] = 8'd5;
    imgMem[17] = 8'd3;
  endtask

  task automatic randomImage();
    bit [2:0] op;
    for (int a = 0; a < 32; a++) begin
      op = 3'($urandom_range(0, 7));
      if (op == 3'd7 && $urandom_range(0, 3) != 0) op = 3'd6;
      imgMem[a] = {op, 5'($urandom_range(0, 31))};
    end
  endtask

  // One cycle of randomized stimulus: occasional resets, sometimes with a fresh program.
  task automatic applyStimulus();
    @(posedge CLK); #1;
`ifdef MP8_SINGLE_STEP_EN
    step = ($urandom_range(0, 3) != 0);
`endif
    if (halted === 1'b1) haltCount++;
    else haltCount = 0;
    if (haltCount > 4 || $urandom_range(0, 79) == 0) begin
      haltCount = 0;
      if ($urandom_range(0, 2) == 0) begin
        randomImage();
        doReset(1'b1);
      end else begin
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
      end
    end
  endtask

  initial begin
    RST = 1'b1;
    loadAll = 1'b0;
`ifdef MP8_SINGLE_STEP_EN
    step = 1'b1;
`endif
    clearImage();

    // Reset with all-zero memory: LDA 0 is the first instruction.
    doReset(1'b1);
    waitCycle();
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_WE", WE, 0);
    checkOutput("rst_pc", pc, 0);
    checkOutput("rst_halted", halted, 0);
    checkOutput("rst_acc_we", acc_we, 0);
    waitCycle();
    checkOutput("first_fetch_pc", pc, 1);
    checkOutput("first_fetch_ir", ir, 0);

    // LDA 16 / ADD 17 / STA 18 / HLT.
    loadProgB();
    doReset(1'b1);
    for (int c = 0; c < 12; c++) begin
      waitCycle();
      if (c == 2) begin
        checkOutput("lda_acc_we", acc_we, 1);
        checkOutput("lda_alu_op", alu_op, 2'b00);
        checkOutput("lda_addr", addr, 16);
      end
      if (c == 5) begin
        checkOutput("add_acc_we", acc_we, 1);
        checkOutput("add_alu_op", alu_op, 2'b01);
      end
      if (c == 8) begin
        checkOutput("sta_WE", WE, 1);
        checkOutput("sta_addr", addr, 18);
        checkOutput("sta_WD", WD, 8);
        checkOutput("sta_acc_we", acc_we, 0);
      end
      if (c == 10) checkOutput("pre_halt", halted, 0);
      if (c == 11) begin
        checkOutput("halt_rise", halted, 1);
        checkOutput("halt_pc", pc, 4);
      end
    end
    checkOutput("sta_mem18", envMem[18], 8);

    // JZ 7 taken with acc==0, not taken with acc==1.
    for (int zv = 0; zv < 2; zv++) begin
      clearImage();
      imgMem[0]  = 8'b000_10000;
      imgMem[1]  = 8'b101_00111;
      imgMem[2]  = 8'hE0;
      imgMem[7]  = 8'hE0;
      imgMem[16] = 8'(zv);
      doReset(1'b1);
      for (int c = 0; c < 6; c++) begin
        waitCycle();
        if (c == 4) begin
          checkOutput("jz_dec_WE", WE, 0);
          checkOutput("jz_dec_acc_we", acc_we, 0);
        end
        if (c == 5) begin
          checkOutput("jz_pc", pc, (zv == 0) ? 7 : 2);
          checkOutput("jz_addr", addr, (zv == 0) ? 7 : 2);
        end
      end
    end

    // JMP 31 then NOP at 31: PC wraps to 0.
    clearImage();
    imgMem[0]  = 8'b100_11111;
    imgMem[31] = 8'b110_00000;
    doReset(1'b1);
    for (int c = 0; c < 5; c++) begin
      waitCycle();
      if (c == 2) checkOutput("wrap_fetch_addr", addr, 31);
      if (c == 3) checkOutput("wrap_pc", pc, 0);
      if (c == 4) checkOutput("wrap_next_addr", addr, 0);
    end

    // Reset during STORE, then reset during HALT.
    loadProgB();
    doReset(1'b1);
    for (int c = 0; c < 9; c++) waitCycle();
    checkOutput("cut_store_WE", WE, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    for (int c = 0; c < 8; c++) begin
      waitCycle();
      checkOutput("post_cut_WE", WE, 0);
      if (c == 0) begin
        checkOutput("post_cut_pc", pc, 0);
        checkOutput("post_cut_addr", addr, 0);
      end
    end
    for (int c = 8; c < 12; c++) waitCycle();
    checkOutput("rehalt", halted, 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    waitCycle();
    checkOutput("halt_reset_halted", halted, 0);
    checkOutput("halt_reset_pc", pc, 0);

`ifdef MP8_SINGLE_STEP_EN
    // Step held low freezes FETCH; one pulse completes exactly one instruction.
    loadProgB();
    step = 1'b0;
    doReset(1'b1);
    for (int c = 0; c < 10; c++) begin
      waitCycle();
      checkOutput("step_hold_pc", pc, 0);
      checkOutput("step_hold_ir", ir, 0);
    end
    step = 1'b1;
    waitCycle();
    step = 1'b0;
    for (int c = 0; c < 6; c++) waitCycle();
    checkOutput("step_one_pc", pc, 1);
    checkOutput("step_one_ir", ir, 8'h10);
    checkOutput("step_one_acc", accEnv, 5);
    checkOutput("step_one_addr", addr, 1);
    step = 1'b1;
`endif

    // Randomized programs and resets, checked cycle by cycle against the model.
    randomImage();
    doReset(1'b1);
    for (int i = 0; i < 3000; i++) applyStimulus();

    @(negedge CLK);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
